// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 signed-coefficient convolution over raster-order video, valid-only windows.
// Latency: 2 cycles from the accepting edge to valid_out/pixel_out/frame_done (products, then sum/shift/saturate).
// Backpressure: none; valid_in bubbles hold counters, line buffers and window, and the consumer takes every valid_out.
module conv3x3_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COEF_WIDTH = 8,
    parameter int SHIFT      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in,
    input  logic [DATA_WIDTH-1:0]         pixel_in,
    input  logic                          coef_we,
    input  logic [3:0]                    coef_addr,
    input  logic [COEF_WIDTH-1:0]         coef_data,
    output logic                          valid_out,
    output logic [DATA_WIDTH-1:0]         pixel_out,
    output logic                          frame_done,
    output logic [$clog2(IMG_WIDTH)-1:0]  in_col,
    output logic [$clog2(IMG_HEIGHT)-1:0] in_row
);

    localparam int CW    = $clog2(IMG_WIDTH);
    localparam int RW    = $clog2(IMG_HEIGHT);
    // Nine products of a zero-extended pixel and a signed coefficient never overflow this width.
    localparam int ACC_W = DATA_WIDTH + COEF_WIDTH + 4;
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DATA_WIDTH) - 1);

    // Raster position of the next pixel to be accepted
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;

    // Kernel, index 0 = top-left (oldest row, oldest column)
    logic [COEF_WIDTH-1:0] coef_q [9];

    // Row storage: lb1 holds row r-1, lb2 holds row r-2, both indexed by column
    logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb2_q [IMG_WIDTH];

    // 3x3 window, [row][col], row 0 oldest, col 2 newest
    logic [DATA_WIDTH-1:0] win_d [3][3];

    // Stage 1: products of the freshly shifted window
    logic signed [ACC_W-1:0] prod_d [9];
    logic signed [ACC_W-1:0] prod_q [9];
    logic                    v1_q;
    logic                    last1_q;

    // Stage 2: accumulated sum feeding shift/saturate
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;
    logic                    v2_q;
    logic                    last2_q;

    logic signed [ACC_W-1:0] shifted;
    logic [DATA_WIDTH-1:0]   sat_d;

    logic                    valid_out_q;
    logic                    frame_done_q;
    logic [DATA_WIDTH-1:0]   pixel_out_q;

    logic [DATA_WIDTH-1:0]   win_q [3][3];

    logic col_last;
    logic row_last;
    logic win_ok;

    assign col_last = (col_q == CW'(IMG_WIDTH - 1));
    assign row_last = (row_q == RW'(IMG_HEIGHT - 1));
    // A full window exists only once two rows and two columns of the frame are behind us.
    assign win_ok   = (row_q >= RW'(2)) && (col_q >= CW'(2));

    // Next window: shift left and bring in the column {row r-2, row r-1, incoming pixel}
    always_comb begin
        win_d = win_q;
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = lb2_q[col_q];
        win_d[1][2] = lb1_q[col_q];
        win_d[2][2] = pixel_in;
    end

    // Products use the coefficient registers as they stand before any same-cycle write
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            prod_d[k] = $signed({{(ACC_W - DATA_WIDTH){1'b0}}, win_d[k / 3][k % 3]})
                      * $signed({{(ACC_W - COEF_WIDTH){coef_q[k][COEF_WIDTH-1]}}, coef_q[k]});
        end
    end

    // Sum of the registered products
    always_comb begin
        acc_d = '0;
        for (int k = 0; k < 9; k++) begin
            acc_d = acc_d + prod_q[k];
        end
    end

    // Floor shift then clamp into the unsigned pixel range
    always_comb begin
        shifted = acc_q >>> SHIFT;
        sat_d   = shifted[DATA_WIDTH-1:0];
        if (shifted[ACC_W-1]) begin
            sat_d = '0;
        end else if (shifted > PIX_MAX) begin
            sat_d = '1;
        end
    end

    // Column/row counters advance only on accepted pixels; frames follow each other with no gap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (valid_in) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Coefficient file, identity kernel out of reset; addresses beyond 8 are dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 9; k++) begin
                coef_q[k] <= (k == 4) ? COEF_WIDTH'(1 << SHIFT) : '0;
            end
        end else if (coef_we && (coef_addr <= 4'd8)) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    // Line buffers and window hold across bubbles; contents are rewritten before any use after reset
    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb1_q[col_q] <= pixel_in;
            lb2_q[col_q] <= lb1_q[col_q];
            win_q        <= win_d;
        end
    end

    // Product and sum stages advance every cycle so latency is independent of bubbles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            acc_q   <= '0;
            for (int k = 0; k < 9; k++) begin
                prod_q[k] <= '0;
            end
        end else begin
            v1_q    <= valid_in && win_ok;
            last1_q <= valid_in && win_ok && col_last && row_last;
            prod_q  <= prod_d;
            v2_q    <= v1_q;
            last2_q <= last1_q;
            acc_q   <= acc_d;
        end
    end

    // Registered outputs; pixel_out holds its last value between valid results
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pixel_out_q  <= '0;
        end else begin
            valid_out_q  <= v2_q;
            frame_done_q <= last2_q;
            if (v2_q) begin
                pixel_out_q <= sat_d;
            end
        end
    end

    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;
    assign pixel_out  = pixel_out_q;
    assign in_col     = col_q;
    assign in_row     = row_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: directed and randomized frames on a 5x4 image against an image-level reference model.
// Latency: expected outputs are scheduled exactly 2 cycles after each accepting edge.
// Backpressure: none; every valid_out must match a scheduled expectation.
module tb_conv3x3_stream;

    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int CWID = 8;
    localparam int SH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic [7:0] pixel_in;
    logic       coef_we;
    logic [3:0] coef_addr;
    logic [7:0] coef_data;
    logic       valid_out;
    logic [7:0] pixel_out;
    logic       frame_done;
    logic [2:0] in_col;
    logic [1:0] in_row;

    always #5 clk = ~clk;

    conv3x3_stream #(
        .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .COEF_WIDTH(CWID), .SHIFT(SH)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pixel_in(pixel_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .valid_out(valid_out), .pixel_out(pixel_out), .frame_done(frame_done),
        .in_col(in_col), .in_row(in_row)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int k        = 0;
    bit exp_vld [8192];
    int exp_pix [8192];
    bit exp_fd  [8192];
    int mcoef [9];
    int img [H][W];
    int mrow, mcol;
    int got_q [$];
    int fd_cnt = 0;
    int fv, sv;
    bit pend_we = 0;
    int pend_addr, pend_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_assert++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic int pix_of(input int kind, input int r, input int c);
        case (kind)
            0:       return r * W + c;
            1:       return fv;
            2:       return int'($urandom_range(255));
            default: return (r == 1 && c == 2) ? sv : fv;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 9; i++) mcoef[i] = 0;
        mcoef[4] = 1 << SH;
        mrow = 0;
        mcol = 0;
    endfunction

    // Convolution of the window ending at the model position, straight from the image array
    function automatic int conv_at(input int r, input int c);
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += mcoef[i * 3 + j] * img[r - 2 + i][c - 2 + j];
        s = s >>> SH;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    // One clock: check what the previous edge produced, then drive this cycle's inputs
    task automatic step(input bit v, input int pix, input bit we, input int addr, input int data);
        @(negedge clk);
        chk("valid_out", valid_out, exp_vld[k]);
        if (exp_vld[k]) chk("pixel_out", pixel_out, exp_pix[k]);
        chk("frame_done", frame_done, exp_fd[k]);
        chk("in_col", in_col, mcol);
        chk("in_row", in_row, mrow);
        if (valid_out === 1'b1) got_q.push_back(int'(pixel_out));
        if (frame_done === 1'b1) fd_cnt++;
        valid_in  = v;
        pixel_in  = pix[7:0];
        coef_we   = we;
        coef_addr = addr[3:0];
        coef_data = data[7:0];
        if (v) begin
            img[mrow][mcol] = pix;
            if (mrow >= 2 && mcol >= 2) begin
                exp_vld[k + 3] = 1'b1;
                exp_pix[k + 3] = conv_at(mrow, mcol);
                exp_fd[k + 3]  = (mrow == H - 1 && mcol == W - 1);
            end
            if (mcol == W - 1) begin
                mcol = 0;
                mrow = (mrow == H - 1) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
        end
        if (we && addr <= 8) mcoef[addr] = data;
        k++;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        reset = 1'b0;
        valid_in = 1'b0;
        coef_we = 1'b0;
        #1;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_pixel_out", pixel_out, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_in_col", in_col, 0);
        chk("rst_in_row", in_row, 0);
        model_reset();
        for (int i = k; i < k + 5; i++) begin
            exp_vld[i] = 1'b0;
            exp_fd[i]  = 1'b0;
        end
        k++;
        @(negedge clk);
        chk("rst_hold_valid", valid_out, 0);
        reset = 1'b1;
        k++;
    endtask

    task automatic frame(input int kind, input bit bub, input bit wrand);
        int n = 0;
        while (n < W * H) begin
            bit v;
            bit we;
            int a, d;
            v  = bub ? ($urandom_range(1) == 1) : 1'b1;
            we = 1'b0;
            a  = 0;
            d  = 0;
            if (pend_we) begin
                we = 1'b1; a = pend_addr; d = pend_data; pend_we = 1'b0;
            end else if (wrand && $urandom_range(3) == 0) begin
                we = 1'b1;
                a  = int'($urandom_range(15));
                d  = int'($urandom_range(32)) - 16;
            end
            step(v, v ? pix_of(kind, mrow, mcol) : int'($urandom_range(255)), we, a, d);
            if (v) n++;
        end
    endtask

    task automatic drain();
        repeat (4) step(1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic set_coefs(input int c[9]);
        for (int i = 0; i < 9; i++) step(1'b0, 0, 1'b1, i, c[i]);
    endtask

    task automatic chk_list(input string tag, input int e[6]);
        chk({tag, "_count"}, got_q.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < got_q.size()) chk(tag, got_q[i], e[i]);
    endtask

    initial begin
        int cv[9];
        int e6[6];
        int fd0;
        reset = 1'b0; valid_in = 1'b0; pixel_in = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        model_reset();
        rst_pulse();

        // Identity kernel on a ramp 5r+c, continuous
        e6 = '{6, 7, 8, 11, 12, 13};
        got_q.delete(); fd0 = fd_cnt;
        frame(0, 1'b0, 1'b0); drain();
        chk_list("ident_ramp", e6);
        chk("ident_fd_count", fd_cnt - fd0, 1);

        // Same with random bubbles
        got_q.delete();
        frame(0, 1'b1, 1'b0); drain();
        chk_list("ident_bubbles", e6);

        // A write to address 9 must not disturb the kernel
        step(1'b0, 0, 1'b1, 9, 99);
        got_q.delete();
        frame(0, 1'b0, 1'b0); drain();
        chk_list("addr9_ignored", e6);

        // Box blur on flat 32: 9*32 >>> 4 = 18
        cv = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        set_coefs(cv);
        fv = 32; got_q.delete();
        frame(1, 1'b0, 1'b0); drain();
        e6 = '{18, 18, 18, 18, 18, 18};
        chk_list("box_flat32", e6);

        // Box x16 on flat 255 saturates high
        cv = '{16, 16, 16, 16, 16, 16, 16, 16, 16};
        set_coefs(cv);
        fv = 255; got_q.delete();
        frame(1, 1'b1, 1'b0); drain();
        e6 = '{255, 255, 255, 255, 255, 255};
        chk_list("box_sat_high", e6);

        // Edge kernel: flat field cancels
        cv = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
        set_coefs(cv);
        fv = 100; got_q.delete();
        frame(1, 1'b0, 1'b0); drain();
        e6 = '{0, 0, 0, 0, 0, 0};
        chk_list("edge_flat", e6);

        // Bright spot at (1,2): centre 50, neighbours floor(-6.25) -> clamp 0
        sv = 200; got_q.delete();
        frame(3, 1'b0, 1'b0); drain();
        e6 = '{0, 50, 0, 0, 0, 0};
        chk_list("edge_spot200", e6);

        // Dark spot at (1,2): centre -50 -> 0, neighbours 100>>>4 = 6
        sv = 0; got_q.delete();
        frame(3, 1'b0, 1'b0); drain();
        e6 = '{6, 0, 6, 6, 6, 6};
        chk_list("edge_spot0", e6);

        // Back-to-back frames, centre coefficient doubled on the first pixel of frame 2
        cv = '{0, 0, 0, 0, 16, 0, 0, 0, 0};
        set_coefs(cv);
        got_q.delete(); fd0 = fd_cnt;
        frame(0, 1'b0, 1'b0);
        pend_we = 1'b1; pend_addr = 4; pend_data = 32;
        frame(0, 1'b0, 1'b0); drain();
        chk("b2b_fd_count", fd_cnt - fd0, 2);
        chk("b2b_out_count", got_q.size(), 12);
        e6 = '{12, 14, 16, 22, 24, 26};
        for (int i = 0; i < 6; i++)
            if (i + 6 < got_q.size()) chk("b2b_frame2", got_q[i + 6], e6[i]);

        // Random pixels, bubbles and coefficient writes at any time, back to back
        for (int i = 0; i < 9; i++) cv[i] = int'($urandom_range(32)) - 16;
        set_coefs(cv);
        repeat (4) frame(2, 1'b1, 1'b1);
        drain();

        // Reset after pixel 8 of a frame, then a clean frame with the identity kernel restored
        cv = '{2, 0, 0, 0, 3, 0, 0, 0, 1};
        set_coefs(cv);
        for (int i = 0; i < 9; i++) step(1'b1, pix_of(0, mrow, mcol), 1'b0, 0, 0);
        rst_pulse();
        got_q.delete(); fd0 = fd_cnt;
        frame(0, 1'b0, 1'b0); drain();
        e6 = '{6, 7, 8, 11, 12, 13};
        chk_list("after_reset", e6);
        chk("after_reset_fd", fd_cnt - fd0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
